// File: rtl/jolt_pkg.sv
// Shared types and helpers for the joltage finder: BCD digit type, index type
// and the digit validity / sanitising functions.
package jolt_pkg;

  localparam int BCD_W      = 4;
  localparam int IDX_W      = 4;
  localparam int MAX_DIGITS = 16;

  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= bcd_digit_t'(9));
  endfunction

  // Out-of-range nibbles are read as zero so they never win a selection.
  function automatic bcd_digit_t sanitize_digit(input bcd_digit_t d);
    return is_bcd(d) ? d : '0;
  endfunction

endpackage

// File: rtl/max_digit_scan.sv
// Combinational scan: largest digit within [lo_i, hi_i] and the first index
// at which it occurs (strict compare keeps the lowest index on ties).
module max_digit_scan
  import jolt_pkg::*;
#(
  parameter int N = 5
) (
  input  bcd_digit_t digits_i [N],
  input  idx_t       lo_i,
  input  idx_t       hi_i,
  output bcd_digit_t max_o,
  output idx_t       idx_o
);

  bcd_digit_t best;
  idx_t       best_idx;

  always_comb begin
    best     = '0;
    best_idx = lo_i;
    for (int i = 0; i < N; i++) begin
      if ((i >= int'(lo_i)) && (i <= int'(hi_i)) && (digits_i[i] > best)) begin
        best     = digits_i[i];
        best_idx = idx_t'(i);
      end
    end
  end

  assign max_o = best;
  assign idx_o = best_idx;

endmodule

// File: rtl/jolt_finder.sv
// Largest two-digit joltage from a bank of BCD digits: tens from indices
// 0..N-2, units from strictly right of the tens pick; result registered once.
module jolt_finder
  import jolt_pkg::*;
#(
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] bcdIn,
  output logic                    out_valid,
  output logic [7:0]              maxJoltBCD,
  output logic [7:0]              pos,
  output logic                    bcd_err
);

  // Handshake: in_valid qualifies bcdIn; there is no ready, every beat is
  // accepted; out_valid is in_valid delayed by exactly one cycle.

  bcd_digit_t digits [NUM_DIGITS];
  logic       err_d;

  // Digit 0 is the leftmost (most significant) nibble of bcdIn.
  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[i] = sanitize_digit(bcdIn[BCD_W*(NUM_DIGITS-1-i) +: BCD_W]);
      err_d     = err_d | ~is_bcd(bcdIn[BCD_W*(NUM_DIGITS-1-i) +: BCD_W]);
    end
  end

  bcd_digit_t tens_digit, units_digit;
  idx_t       tens_idx, units_idx;
  idx_t       units_lo;

  max_digit_scan #(.N(NUM_DIGITS)) u_tens_scan (
    .digits_i (digits),
    .lo_i     ('0),
    .hi_i     (idx_t'(NUM_DIGITS - 2)),
    .max_o    (tens_digit),
    .idx_o    (tens_idx)
  );

  // tens_idx <= N-2, so the units window is never empty.
  assign units_lo = idx_t'(tens_idx + idx_t'(1));

  max_digit_scan #(.N(NUM_DIGITS)) u_units_scan (
    .digits_i (digits),
    .lo_i     (units_lo),
    .hi_i     (idx_t'(NUM_DIGITS - 1)),
    .max_o    (units_digit),
    .idx_o    (units_idx)
  );

  logic       out_valid_q;
  logic [7:0] jolt_q, jolt_d;
  logic [7:0] pos_q, pos_d;
  logic       err_q;

  assign jolt_d = {tens_digit, units_digit};
  assign pos_d  = {tens_idx, units_idx};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      jolt_q      <= '0;
      pos_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        jolt_q <= jolt_d;
        pos_q  <= pos_d;
        err_q  <= err_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign maxJoltBCD = jolt_q;
  assign pos        = pos_q;
  assign bcd_err    = err_q;

endmodule

// File: tb/tb_jolt_finder.sv
// Scoreboard bench for jolt_finder: directed banks plus randomized banks
// checked against an exhaustive pair-search reference model.
module tb_jolt_finder;

  localparam int N = 5;
  localparam int W = 17;  // {err, jolt[7:0], pos[7:0]}

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [4*N-1:0] bcdIn;
  logic           out_valid;
  logic [7:0]     maxJoltBCD;
  logic [7:0]     pos;
  logic           bcd_err;

  int tests  = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;
  logic         samp_v   = 1'b0;
  logic         samp_rst = 1'b0;

  jolt_finder #(.NUM_DIGITS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .bcdIn      (bcdIn),
    .out_valid  (out_valid),
    .maxJoltBCD (maxJoltBCD),
    .pos        (pos),
    .bcd_err    (bcd_err)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: try every ordered pair i<j, keep the largest 10*a+b value;
  // scanning i then j ascending with strict > keeps the lowest indices on ties.
  function automatic logic [W-1:0] model(input logic [4*N-1:0] bank);
    int d[N];
    logic err;
    int best, bi, bj, v;
    err = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = int'(bank[4*(N-1-i) +: 4]);
      if (v > 9) begin
        err = 1'b1;
        v   = 0;
      end
      d[i] = v;
    end
    best = -1; bi = 0; bj = 1;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (10 * d[i] + d[j] > best) begin
          best = 10 * d[i] + d[j];
          bi = i;
          bj = j;
        end
    return {err, 4'(d[bi]), 4'(d[bj]), 4'(bi), 4'(bj)};
  endfunction

  // driver tasks
  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      bcdIn    = 20'($urandom);
    end
  endtask

  task automatic send_exp(input logic [4*N-1:0] bank, input logic [W-1:0] exp_v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    bcdIn    = bank;
    exp_q.push_back(exp_v);
  endtask

  task automatic send(input logic [4*N-1:0] bank);
    send_exp(bank, model(bank));
  endtask

  task automatic reset_with_valid(input logic [4*N-1:0] bank);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    bcdIn    = bank;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  function automatic logic [4*N-1:0] rand_bank();
    logic [4*N-1:0] b;
    for (int i = 0; i < N; i++)
      b[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
    return b;
  endfunction

  // What the DUT saw at each edge, from the bench's own drive values.
  always @(posedge clk) begin
    samp_v   <= in_valid & rst_n;
    samp_rst <= ~rst_n;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got, exp_v;
    got = {bcd_err, maxJoltBCD, pos};
    tests++;
    if (out_valid !== samp_v) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, samp_v, $time);
    end
    if (samp_rst) begin
      last_exp = '0;
      tests++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 0 at %0t", got, $time);
      end
    end else if (samp_v) begin
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: got %h expected nothing (queue empty) at %0t", got, $time);
      end else begin
        exp_v = exp_q.pop_front();
        last_exp = exp_v;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL result: got err=%b jolt=%h pos=%h expected err=%b jolt=%h pos=%h at %0t",
                   got[16], got[15:8], got[7:0], exp_v[16], exp_v[15:8], exp_v[7:0], $time);
        end
      end
    end else begin
      tests++;
      if (got !== last_exp) begin
        errors++;
        $display("FAIL hold: got %h expected %h at %0t", got, last_exp, $time);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bcdIn    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // directed banks with hand-derived results
    send_exp(20'h12984, {1'b0, 8'h98, 8'h23});
    idle(1);
    send_exp(20'h11111, {1'b0, 8'h11, 8'h01});
    idle(1);
    send_exp(20'h12349, {1'b0, 8'h49, 8'h34});
    send_exp(20'h90009, {1'b0, 8'h99, 8'h04});
    send_exp(20'h12984, {1'b0, 8'h98, 8'h23});
    send_exp(20'h1A234, {1'b1, 8'h34, 8'h34});
    send_exp(20'h00000, {1'b0, 8'h00, 8'h01});
    send_exp(20'h98765, {1'b0, 8'h98, 8'h01});
    send_exp(20'h0FFFF, {1'b1, 8'h00, 8'h01});
    idle(3);

    // reset beats an in-flight valid, then a fresh beat works
    reset_with_valid(20'h99999);
    idle(1);
    send_exp(20'h12984, {1'b0, 8'h98, 8'h23});
    idle(2);

    // randomized traffic with gaps and back-to-back runs
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else send(rand_bank());
      if (k == 200) reset_with_valid(rand_bank());
    end
    idle(4);

    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
